wb_arbiter2: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter with a registered grant and round-robin fairness.
- Shares the single memory/peripheral bus between the CPU instruction-fetch/data port (master 0) and a second bus master such as a DMA or debug port (master 1).
- Includes a bus watchdog: it terminates a stalled cycle with an error so a master never hangs on a missing ack.

---
 rtl/wb_arbiter2.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone classic arbiter with round-robin grant and bus watchdog
//
// Purpose: shares one Wishbone slave between master 0 (CPU) and master 1 (DMA/debug).
// Ownership is registered: a request seen at an edge is granted from the next cycle,
// and every ownership change passes through one idle cycle. A watchdog ends a strobe
// that has gone TIMEOUT_CYCLES cycles without ack/err/rty by returning err to the owner.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m0_*/m1_* (cyc,stb,we,adr,sel,dat_i)  master requests
//   m0_*/m1_* (dat_o,ack,err,rty) master responses (dat_o is always s_dat_i)
//   s_* (cyc,stb,we,adr,sel,dat_o)        slave-side request, routed from the owner
//   s_dat_i, s_ack_i, s_err_i, s_rty_i    slave response
//   grant_o                      one-hot owner, 00 when idle
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o
);

  // A zero limit would give a zero-width counter; keep one bit that never moves.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, OWN0, OWN1, TOUT0, TOUT1} state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic own_cyc, own_stb, own_is_m1, term, stalled, wd_hit;

  assign own_is_m1 = (state == OWN1);
  assign own_cyc   = own_is_m1 ? m1_cyc_i : m0_cyc_i;
  assign own_stb   = own_is_m1 ? m1_stb_i : m0_stb_i;
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign stalled   = own_stb && !term;
  // Fire on the edge where the count would reach the limit, so a termination
  // arriving in that same cycle still wins.
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && stalled &&
                     ((32'(cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = '0;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_grant ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_nxt = OWN0;
        else if (m1_cyc_i)        state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = own_is_m1;
        end else if (wd_hit) begin
          state_nxt = own_is_m1 ? TOUT1 : TOUT0;
        end else if (stalled && TIMEOUT_CYCLES != 0) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      TOUT0: begin
        if (m0_cyc_i) state_nxt = OWN0;
        else begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      TOUT1: begin
        if (m1_cyc_i) state_nxt = OWN1;
        else begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    grant_o  = 2'b00;
    if (!rst_i) begin
      case (state)
        OWN0: begin
          s_cyc_o  = m0_cyc_i;
          s_stb_o  = m0_stb_i;
          s_we_o   = m0_we_i;
          s_adr_o  = m0_adr_i;
          s_sel_o  = m0_sel_i;
          s_dat_o  = m0_dat_i;
          m0_ack_o = s_ack_i;
          m0_err_o = s_err_i;
          m0_rty_o = s_rty_i;
          grant_o  = 2'b01;
        end
        OWN1: begin
          s_cyc_o  = m1_cyc_i;
          s_stb_o  = m1_stb_i;
          s_we_o   = m1_we_i;
          s_adr_o  = m1_adr_i;
          s_sel_o  = m1_sel_i;
          s_dat_o  = m1_dat_i;
          m1_ack_o = s_ack_i;
          m1_err_o = s_err_i;
          m1_rty_o = s_rty_i;
          grant_o  = 2'b10;
        end
        TOUT0: begin
          m0_err_o = 1'b1;
          grant_o  = 2'b01;
        end
        TOUT1: begin
          m1_err_o = 1'b1;
          grant_o  = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed scoreboard bench for wb_arbiter2
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  // Termination vector order: {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}
  localparam logic [5:0] T_M0_ACK = 6'b100000;
  localparam logic [5:0] T_M1_ACK = 6'b000100;
  localparam logic [5:0] T_M1_ERR = 6'b000010;

  typedef struct {
    logic [5:0]  term;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void expect_term(input logic [5:0] t, input logic [31:0] d, input logic c);
    exp_t e;
    e.term = t;
    e.data = d;
    e.chk_data = c;
    sb.push_back(e);
  endfunction

  task automatic mon();
    logic [5:0] t;
    exp_t e;
    t = {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
    if (t != 6'b0) begin
      if (sb.size() == 0) chk("unexpected_term", 32'(t), 32'd0);
      else begin
        e = sb.pop_front();
        chk("term", 32'(t), 32'(e.term));
        if (e.chk_data) chk("rdata", t[5] ? m0_dat_o : m1_dat_o, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
    mon();
  endtask

  initial begin
    rst_i = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hf;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hf;
    s_dat_i = '0; {s_ack_i, s_err_i, s_rty_i} = '0;

    // Reset
    step(); look();
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    step(); rst_i = 1'b0;

    // Single request from m0
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100;
    look();
    chk("t1_cyc_pre", 32'(s_cyc_o), 32'd0);
    chk("t1_grant_pre", 32'(grant_o), 32'd0);
    step(); look();
    chk("t1_cyc", 32'(s_cyc_o), 32'd1);
    chk("t1_adr", s_adr_o, 32'h0000_0100);
    chk("t1_grant", 32'(grant_o), 32'd1);
    chk("t1_noack", 32'(m0_ack_o), 32'd0);
    step(); s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    expect_term(T_M0_ACK, 32'hDEAD_BEEF, 1'b1);
    look();
    chk("t1_ack", 32'(m0_ack_o), 32'd1);
    step(); s_ack_i = 0; s_dat_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
    look();
    chk("t1_ack_once", 32'(m0_ack_o), 32'd0);
    chk("t1_grant_rel", 32'(grant_o), 32'd1);
    step(); look();
    chk("t1_grant_idle", 32'(grant_o), 32'd0);

    // Tie after reset, then alternating ties
    rst_i = 1;
    step(); rst_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h300;
    look();
    chk("t2_grant_pre", 32'(grant_o), 32'd0);
    step(); look();
    chk("t2_tie1_m0", 32'(grant_o), 32'd1);
    chk("t2_adr0", s_adr_o, 32'h200);
    step(); s_ack_i = 1; s_dat_i = 32'h1111_2222;
    expect_term(T_M0_ACK, 32'h1111_2222, 1'b1);
    look();
    chk("t2_m1_noack", 32'(m1_ack_o), 32'd0);
    step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    look();
    chk("t2_grant_rel", 32'(grant_o), 32'd1);
    step(); look();
    chk("t2_dead_grant", 32'(grant_o), 32'd0);
    chk("t2_dead_cyc", 32'(s_cyc_o), 32'd0);
    step(); look();
    chk("t2_m1", 32'(grant_o), 32'd2);
    chk("t2_adr1", s_adr_o, 32'h300);
    step(); s_ack_i = 1; s_dat_i = 32'h3333_4444;
    expect_term(T_M1_ACK, 32'h3333_4444, 1'b1);
    look();
    step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    look();
    step(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    look();
    chk("t2_tie2_pre", 32'(grant_o), 32'd0);
    step(); look();
    chk("t2_tie2_m0", 32'(grant_o), 32'd1);
    step(); s_ack_i = 1;
    expect_term(T_M0_ACK, 32'h0, 1'b0);
    look();
    step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    look();
    step(); m0_cyc_i = 1; m0_stb_i = 1;
    look();
    chk("t2_tie3_pre", 32'(grant_o), 32'd0);
    step(); look();
    chk("t2_tie3_m1", 32'(grant_o), 32'd2);
    step(); s_ack_i = 1;
    expect_term(T_M1_ACK, 32'h0, 1'b0);
    look();
    step(); s_ack_i = 0;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
    look();
    step(); look();
    chk("t2_end_idle", 32'(grant_o), 32'd0);

    // Busy bus: m1 waits behind m0, then its write stalls into the watchdog
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
    step();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h20; m1_dat_i = 32'hCAFE_0001;
    look();
    chk("t3_adr_a", s_adr_o, 32'h10);
    chk("t3_m1_noack_a", 32'(m1_ack_o), 32'd0);
    step(); look();
    chk("t3_adr_b", s_adr_o, 32'h10);
    step(); s_ack_i = 1;
    expect_term(T_M0_ACK, 32'h0, 1'b0);
    look();
    chk("t3_m1_noack_b", 32'(m1_ack_o), 32'd0);
    chk("t3_adr_c", s_adr_o, 32'h10);
    step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    look();
    chk("t3_grant_fall", 32'(grant_o), 32'd1);
    step(); look();
    chk("t3_dead", 32'(grant_o), 32'd0);
    step();
    expect_term(T_M1_ERR, 32'h0, 1'b0);
    look();
    chk("t3_m1_grant", 32'(grant_o), 32'd2);
    chk("t3_adr_m1", s_adr_o, 32'h20);
    chk("t3_we", 32'(s_we_o), 32'd1);
    chk("t3_wdat", s_dat_o, 32'hCAFE_0001);
    step(); look();
    step(); look();
    step(); look();
    chk("t4_stall4_cyc", 32'(s_cyc_o), 32'd1);
    chk("t4_stall4_noerr", 32'(m1_err_o), 32'd0);
    step(); look();
    chk("t4_tout_cyc", 32'(s_cyc_o), 32'd0);
    chk("t4_tout_err", 32'(m1_err_o), 32'd1);
    chk("t4_tout_ack", 32'(m1_ack_o), 32'd0);
    m1_cyc_i = 0; m1_stb_i = 0;
    step(); look();
    chk("t4_idle", 32'(grant_o), 32'd0);

    // Ack in exactly the 4th stalled cycle
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h40;
    step(); look();
    step(); look();
    step(); look();
    step(); s_ack_i = 1;
    expect_term(T_M1_ACK, 32'h0, 1'b0);
    look();
    chk("t5_ack", 32'(m1_ack_o), 32'd1);
    chk("t5_noerr", 32'(m1_err_o), 32'd0);
    step(); s_ack_i = 0;
    look();
    chk("t5_no_tout_cyc", 32'(s_cyc_o), 32'd1);
    chk("t5_no_tout_err", 32'(m1_err_o), 32'd0);
    step(); m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    look();
    chk("t5_rel_noerr", 32'(m1_err_o), 32'd0);
    step(); look();
    chk("t5_idle", 32'(grant_o), 32'd0);

    // Reset in the middle of an m0 access
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h50;
    step(); look();
    chk("t6_cyc", 32'(s_cyc_o), 32'd1);
    step(); rst_i = 1; s_ack_i = 1;
    look();
    chk("t6_rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("t6_rst_grant", 32'(grant_o), 32'd0);
    chk("t6_rst_noack", 32'(m0_ack_o), 32'd0);
    step(); rst_i = 0; s_ack_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
    look();
    chk("t6_post_grant", 32'(grant_o), 32'd0);
    step(); look();
    chk("t6_tie_m0", 32'(grant_o), 32'd1);
    step(); s_ack_i = 1;
    expect_term(T_M0_ACK, 32'h0, 1'b0);
    look();
    step(); s_ack_i = 0;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
    look();
    step(); look();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
